// File: rtl/signal_phase_controller.sv
// Four-way intersection phase sequencer: STARTUP, then GREEN -> YELLOW -> ALL_RED per road, N->E->S->W.
// Optional emergency override build: define EMERGENCY_OVERRIDE_EN.
module signal_phase_controller #(
    parameter int TICK_DIV    = 10,
    parameter int YELLOW_SEC  = 3,
    parameter int ALL_RED_SEC = 1,
    parameter int STARTUP_SEC = 2,
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TGn,
    input  logic [7:0] TGe,
    input  logic [7:0] TGs,
    input  logic [7:0] TGw,
`ifdef EMERGENCY_OVERRIDE_EN
    input  logic       emerg_req,
    input  logic [1:0] emerg_road,
`endif
    output logic [1:0] next_road,
    output logic [1:0] active_road,
    output logic [2:0] lamp_n,
    output logic [2:0] lamp_e,
    output logic [2:0] lamp_s,
    output logic [2:0] lamp_w,
    output logic [7:0] phase_left,
    output logic       cycle_done,
    output logic [1:0] phase_state
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_ALL_RED = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t        state, state_next;
    logic [PW-1:0] prescaler;
    logic          sec_tick;
    logic          expire;
    logic          enter;
    logic          freeze;
    logic          go_yellow;
    logic [1:0]    road_next;
    logic [1:0]    next_road_next;
    logic [7:0]    tg_sel;
    logic [7:0]    load_val;
    logic          cycle_done_next;
    logic [2:0]    lamp_n_next, lamp_e_next, lamp_s_next, lamp_w_next;
`ifdef EMERGENCY_OVERRIDE_EN
    logic          override, override_next;
`endif

    function automatic logic [7:0] clamp_green(input logic [7:0] tg);
        logic [7:0] g;
        g = tg;
        if (tg < 8'(MIN_GREEN)) g = 8'(MIN_GREEN);
        else if (tg > 8'(MAX_GREEN)) g = 8'(MAX_GREEN);
        return g;
    endfunction

    function automatic logic [2:0] lamp_of(input state_t st, input logic [1:0] road,
                                           input logic [1:0] r);
        logic [2:0] l;
        l = 3'b100;
        if (road == r) begin
            if (st == ST_GREEN) l = 3'b001;
            else if (st == ST_YELLOW) l = 3'b010;
        end
        return l;
    endfunction

    assign sec_tick    = (prescaler == TICK_LAST);
    assign expire      = sec_tick && (phase_left == 8'd1);
    assign phase_state = state;

    always_comb begin
        state_next      = state;
        road_next       = active_road;
        next_road_next  = next_road;
        freeze          = 1'b0;
        go_yellow       = 1'b0;
        cycle_done_next = 1'b0;
        tg_sel          = TGn;
        load_val        = phase_left;
`ifdef EMERGENCY_OVERRIDE_EN
        override_next   = override;
`endif
        case (state)
            ST_STARTUP: begin
                if (expire) begin
                    state_next = ST_GREEN;
                    road_next  = 2'd0;
`ifdef EMERGENCY_OVERRIDE_EN
                    override_next = 1'b0;
`endif
                end
            end
            ST_GREEN: begin
`ifdef EMERGENCY_OVERRIDE_EN
                // A request for another road truncates this green; a request for
                // this road freezes it; dropping the request ends an override green.
                if (emerg_req && (emerg_road != active_road)) go_yellow = 1'b1;
                else if (emerg_req) freeze = 1'b1;
                else if (override) go_yellow = 1'b1;
                else go_yellow = expire;
`else
                go_yellow = expire;
`endif
                if (go_yellow) begin
                    state_next     = ST_YELLOW;
                    next_road_next = active_road + 2'd1;
`ifdef EMERGENCY_OVERRIDE_EN
                    override_next  = 1'b0;
`endif
                end
            end
            ST_YELLOW: begin
                if (expire) state_next = ST_ALL_RED;
            end
            ST_ALL_RED: begin
                if (expire) begin
                    state_next      = ST_GREEN;
                    road_next       = next_road;
                    cycle_done_next = (active_road == 2'd3);
`ifdef EMERGENCY_OVERRIDE_EN
                    if (emerg_req) road_next = emerg_road;
                    override_next = emerg_req;
`endif
                end
            end
            default: state_next = ST_STARTUP;
        endcase

        // Green time is taken from the road about to own the phase, on the entry edge.
        case (road_next)
            2'd0:    tg_sel = TGn;
            2'd1:    tg_sel = TGe;
            2'd2:    tg_sel = TGs;
            default: tg_sel = TGw;
        endcase

        case (state_next)
            ST_GREEN:   load_val = clamp_green(tg_sel);
            ST_YELLOW:  load_val = 8'(YELLOW_SEC);
            ST_ALL_RED: load_val = 8'(ALL_RED_SEC);
            default:    load_val = 8'(STARTUP_SEC);
        endcase
    end

    assign enter       = (state_next != state);
    assign lamp_n_next = lamp_of(state_next, road_next, 2'd0);
    assign lamp_e_next = lamp_of(state_next, road_next, 2'd1);
    assign lamp_s_next = lamp_of(state_next, road_next, 2'd2);
    assign lamp_w_next = lamp_of(state_next, road_next, 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_STARTUP;
            prescaler   <= '0;
            phase_left  <= 8'(STARTUP_SEC);
            active_road <= 2'd0;
            next_road   <= 2'd0;
            cycle_done  <= 1'b0;
            lamp_n      <= 3'b100;
            lamp_e      <= 3'b100;
            lamp_s      <= 3'b100;
            lamp_w      <= 3'b100;
        end else begin
            state       <= state_next;
            active_road <= road_next;
            next_road   <= next_road_next;
            cycle_done  <= cycle_done_next;
            lamp_n      <= lamp_n_next;
            lamp_e      <= lamp_e_next;
            lamp_s      <= lamp_s_next;
            lamp_w      <= lamp_w_next;
            if (enter) begin
                prescaler  <= '0;
                phase_left <= load_val;
            end else begin
                prescaler <= sec_tick ? '0 : prescaler + 1'b1;
                if (sec_tick && !freeze) phase_left <= phase_left - 8'd1;
            end
        end
    end

`ifdef EMERGENCY_OVERRIDE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) override <= 1'b0;
        else        override <= override_next;
    end
`endif

endmodule
